max7317_responder: RTL
======================

// Module: max7317_responder
// PURPOSE
//  SPI slave model of the MAX7317 10-port I/O expander: the far end of the SPI link
//  driven by the board's expander master. Decodes 16-bit frames ({R/W, addr[6:0],
//  data[7:0]}, MSB first) and maintains per-port high-Z state. On MISO it returns
//  the previous valid frame; after a read, the low byte carries the port data.
//  Used in system simulation and the loopback test FPGA image.
// PARAMETERS
//  SYNC_STAGES  2       flops in each SPI input synchronizer (>=2)
//  PORT_RESET   10'h3FF port_hiz value after reset (1 = high-Z/input)
// PORTS
//  clk          in   1   system clock; must be >= 4x SCLK frequency
//  reset        in   1   synchronous, active-high
//  sclk         in   1   SPI clock from master (mode 0, idle low)
//  CSn          in   1   chip select, active low, frames a transfer
//  mosi         in   1   serial data from master
//  miso         out  1   serial data to master
//  miso_oe      out  1   1 -> drive miso (CSn low, synchronized)
//  port_in      in   10  sensed pin levels P9..P0
//  port_hiz     out  10  per-port output state: 1 = high-Z, 0 = drive low
//  last_cmd     out  16  last accepted frame
//  frame_done   out  1   1-clk pulse when a valid frame is applied
//  frame_err    out  1   1-clk pulse when a frame is discarded
// BEHAVIOUR
//  Reset values: miso=0, miso_oe=0, port_hiz=PORT_RESET, last_cmd=0, pulses=0,
//   shift/bit counters=0, reply word=16'h0000. Reset mid-frame aborts the frame
//   silently; frame_err is not pulsed.
//  Inputs pass through SYNC_STAGES flops; edges are detected on synchronized signals.
//   mosi uses the same depth as sclk, so it stays aligned.
//  States: IDLE -> (CSn fall) LOAD -> SHIFT -> (CSn rise) COMMIT -> IDLE.
//   LOAD (1 clk): reply shift reg <= reply word; miso <= reply[15]; miso_oe <= 1.
//   SHIFT: on sclk rise: rx <= {rx[14:0], mosi}; bitcnt saturates at 17.
//          on sclk fall: miso <= next reply bit (MSB first); after bit 0, miso <= 0.
//   COMMIT (1 clk): miso_oe <= 0. If bitcnt==16, apply the frame, set last_cmd,
//          pulse frame_done. Otherwise pulse frame_err, leave state and reply unchanged.
//  SCLK edges while CSn is high are ignored. A CSn fall during COMMIT is taken in the
//   next cycle (next LOAD).
//  Latency: port_hiz/last_cmd update on the COMMIT cycle,
//   SYNC_STAGES+1 clk after the raw CSn rise.
//  Write (cmd[15]=0), addr=cmd[14:8], d=cmd[0]:
//   0x00-0x09 port_hiz[addr]<=d; 0x0A all ten <=d; 0x0B [3:0]<=d; 0x0C [7:4]<=d;
//   all other addresses are no-ops, but the frame is still accepted.
//  Read (cmd[15]=1): low byte is sampled from port_in in the COMMIT cycle:
//   0x0E -> port_in[7:0]; 0x0F -> {6'b0, port_in[9:8]};
//   0x00-0x09 -> {7'b0, port_hiz[addr]}; others -> 8'h00.
//  Reply word for the next frame is {cmd[15:8], rd_byte} for reads and cmd for writes.
// STRUCTURE
//  Shared include max7317_defs.v: ADDR_PORT_MAX=7'h09, ADDR_ALL=7'h0A, ADDR_P30=7'h0B,
//   ADDR_P74=7'h0C, ADDR_RD_P70=7'h0E, ADDR_RD_P98=7'h0F, state encodings.
//   The master and this block share the include.
//  One sub-module, spi_sync_edge (synchronizer + rise/fall detect), instantiated for
//   sclk and CSn. mosi uses its plain synchronized output.
// TESTING
//  1 reset -> port_hiz=3FF, last_cmd=0000, miso_oe=0; frame 0x0200 -> MISO returns 0x0000
//  2 frames 0x0A00 then 0x0B01 -> port_hiz 000 then 00F; 2nd MISO=0x0A00, 3rd MISO=0x0B01
//  3 port_in=2A5: 0x8E00, 0x8F00, NOP -> MISO of frames 2,3 = 0x8EA5, 0x8F02
//  4 0x0C00 after all-hiz -> port_hiz=30F; write to addr 0x20 -> port_hiz unchanged,
//    frame_done pulses
//  5 CSn rises after 9 bits of 0x0001 -> frame_err pulse, port_hiz unchanged,
//    next MISO = last valid frame
//  6 reset at bit 8 of 0x0A00 -> port_hiz=3FF, no pulse; next full 0x0A00 -> MISO 0x0000,
//    port_hiz=000

Source files
------------

// File: rtl/max7317_responder_pkg.sv
// max7317_responder_pkg: register map, FSM states and frame decode helpers
// shared by the MAX7317 SPI responder and its synchronizer.
package max7317_responder_pkg;

    localparam logic [6:0] ADDR_PORT_MAX = 7'h09;
    localparam logic [6:0] ADDR_ALL      = 7'h0A;
    localparam logic [6:0] ADDR_P30      = 7'h0B;
    localparam logic [6:0] ADDR_P74      = 7'h0C;
    localparam logic [6:0] ADDR_RD_P70   = 7'h0E;
    localparam logic [6:0] ADDR_RD_P98   = 7'h0F;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_COMMIT} state_e;

    function automatic logic [9:0] apply_write(input logic [9:0] hiz, input logic [6:0] addr,
                                               input logic d);
        apply_write = hiz;
        if (addr <= ADDR_PORT_MAX) apply_write[addr[3:0]] = d;
        else if (addr == ADDR_ALL) apply_write = {10{d}};
        else if (addr == ADDR_P30) apply_write[3:0] = {4{d}};
        else if (addr == ADDR_P74) apply_write[7:4] = {4{d}};
    endfunction

    function automatic logic [7:0] read_byte(input logic [9:0] hiz, input logic [9:0] pins,
                                             input logic [6:0] addr);
        read_byte = (addr == ADDR_RD_P70)   ? pins[7:0] :
                    (addr == ADDR_RD_P98)   ? {6'b0, pins[9:8]} :
                    (addr <= ADDR_PORT_MAX) ? {7'b0, hiz[addr[3:0]]} : 8'h00;
    endfunction

endpackage

// File: rtl/max7317_responder_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall detection on the
// synchronized level. Resets to low so a CSn held low through reset is not seen as a fall.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/max7317_responder.sv
// max7317_responder: SPI slave model of the MAX7317 I/O expander; decodes 16-bit
// frames, keeps per-port high-Z state and echoes the previous valid frame on MISO.
module max7317_responder
    import max7317_responder_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [9:0] PORT_RESET  = 10'h3FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        CSn,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [9:0]  port_in,
    output logic [9:0]  port_hiz,
    output logic [15:0] last_cmd,
    output logic        frame_done,
    output logic        frame_err
);
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .reset(reset), .d(sclk), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_csn (
        .clk(clk), .reset(reset), .d(CSn), .rise(cs_rise), .fall(cs_fall));

    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    state_e                 state_q, state_d;
    logic [15:0]            rx_q, rx_d, sh_q, sh_d, reply_q, reply_d, last_q, last_d;
    logic [4:0]             bitcnt_q, bitcnt_d;
    logic [9:0]             hiz_q, hiz_d;
    logic                   miso_q, miso_d, oe_q, oe_d, done_q, done_d, err_q, err_d;

    always_comb begin
        mosi_d   = {mosi_q[SYNC_STAGES-2:0], mosi};
        state_d  = state_q;
        rx_d     = rx_q;
        sh_d     = sh_q;
        reply_d  = reply_q;
        last_d   = last_q;
        bitcnt_d = bitcnt_q;
        hiz_d    = hiz_q;
        miso_d   = miso_q;
        oe_d     = oe_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: state_d = cs_fall ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                sh_d     = {reply_q[14:0], 1'b0};
                miso_d   = reply_q[15];
                oe_d     = 1'b1;
                rx_d     = '0;
                bitcnt_d = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    rx_d     = {rx_q[14:0], mosi_q[SYNC_STAGES-1]};
                    bitcnt_d = (bitcnt_q == 5'd17) ? 5'd17 : bitcnt_q + 5'd1;
                end
                // sh_q drains to zero, so miso idles low after the last bit
                if (sclk_fall) begin
                    miso_d = sh_q[15];
                    sh_d   = {sh_q[14:0], 1'b0};
                end
                state_d = cs_rise ? ST_COMMIT : ST_SHIFT;
            end
            default: begin
                oe_d    = 1'b0;
                miso_d  = 1'b0;
                state_d = cs_fall ? ST_LOAD : ST_IDLE;
                if (bitcnt_q == 5'd16) begin
                    hiz_d   = rx_q[15] ? hiz_q : apply_write(hiz_q, rx_q[14:8], rx_q[0]);
                    reply_d = rx_q[15] ? {rx_q[15:8], read_byte(hiz_q, port_in, rx_q[14:8])} : rx_q;
                    last_d  = rx_q;
                    done_d  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_q   <= '0;
            state_q  <= ST_IDLE;
            rx_q     <= '0;
            sh_q     <= '0;
            reply_q  <= '0;
            last_q   <= '0;
            bitcnt_q <= '0;
            hiz_q    <= PORT_RESET;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            mosi_q   <= mosi_d;
            state_q  <= state_d;
            rx_q     <= rx_d;
            sh_q     <= sh_d;
            reply_q  <= reply_d;
            last_q   <= last_d;
            bitcnt_q <= bitcnt_d;
            hiz_q    <= hiz_d;
            miso_q   <= miso_d;
            oe_q     <= oe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = oe_q;
    assign port_hiz   = hiz_q;
    assign last_cmd   = last_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
endmodule
